// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction RAM and
// hands captured words to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          DATA_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              busy,
  output logic [15:0]       fetch_count
);

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   ir_d;
  logic [ADDR_W-1:0]   pc_d;
  logic                vld_d;
  logic [15:0]         cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr    <= RESET_PC;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr    <= addr_d;
      ir          <= ir_d;
      ir_pc       <= pc_d;
      ir_valid    <= vld_d;
      fetch_count <= cnt_d;
    end
  end

  // Priority: halt > jump > start > capture.
  always_comb begin
    state_d = state_q;
    addr_d  = mem_addr;
    ir_d    = ir;
    pc_d    = ir_pc;
    vld_d   = ir_valid;
    cnt_d   = fetch_count;
    unique case (state_q)
      IDLE: begin
        if (halt) begin
          vld_d = 1'b0;
        end else if (start) begin
          state_d = FETCH;
          addr_d  = start_addr;
          cnt_d   = '0;
          vld_d   = 1'b0;
        end
      end
      FETCH: begin
        if (halt) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end else if (jump_en) begin
          // word on mem_data belongs to the old PC; drop it
          addr_d = jump_addr;
          vld_d  = 1'b0;
        end else if (!ir_valid || ir_ready) begin
          ir_d   = mem_data;
          pc_d   = mem_addr;
          vld_d  = 1'b1;
          addr_d = mem_addr + 1'b1;
          if (fetch_count != 16'hFFFF)
            cnt_d = fetch_count + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_rd = (state_q == FETCH);
  assign busy   = (state_q == FETCH);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural
// instruction RAM.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic        jump_en = 1'b0;
  logic [15:0] jump_addr = '0;
  logic        halt = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        busy;
  logic [15:0] fetch_count;

  int tests = 0;
  int failed = 0;

  logic [15:0] ram [0:65535];
  logic [15:0] img [0:4];

  always #5 clk = ~clk;

  assign mem_data = mem_rd ? ram[mem_addr] : 16'hzzzz;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .halt       (halt),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .busy       (busy),
    .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic stream5(input string tag);
    for (int k = 0; k < 5; k++) begin
      step();
      chk({tag, "_ir"}, {16'h0, ir}, {16'h0, img[k]});
      chk({tag, "_pc"}, {16'h0, ir_pc}, 32'h10 + k);
      chk({tag, "_vld"}, {31'h0, ir_valid}, 32'd1);
      chk({tag, "_cnt"}, {16'h0, fetch_count}, k + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = dflt(16'(i));
    img[0] = 16'd52;  img[1] = 16'd18; img[2] = 16'd96;
    img[3] = 16'd112; img[4] = 16'd183;
    for (int i = 0; i < 5; i++) ram[16'h10 + i] = img[i];
    ram[5] = 16'd144;

    // async reset asserted mid-cycle
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_rd", {31'h0, mem_rd}, 32'd0);
    chk("rst_ir", {16'h0, ir}, 32'h0);
    chk("rst_pc", {16'h0, ir_pc}, 32'h0);
    chk("rst_vld", {31'h0, ir_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_cnt", {16'h0, fetch_count}, 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_rd", {31'h0, mem_rd}, 32'd0);
    end

    // streaming
    start = 1'b1; start_addr = 16'h0010; ir_ready = 1'b1;
    step();
    start = 1'b0;
    chk("t0_addr", {16'h0, mem_addr}, 32'h10);
    chk("t0_rd", {31'h0, mem_rd}, 32'd1);
    chk("t0_busy", {31'h0, busy}, 32'd1);
    chk("t0_vld", {31'h0, ir_valid}, 32'd0);
    stream5("strm");
    chk("strm_addr", {16'h0, mem_addr}, 32'h15);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt1_rd", {31'h0, mem_rd}, 32'd0);
    chk("halt1_vld", {31'h0, ir_valid}, 32'd0);

    // back-pressure
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("bp_ir0", {16'h0, ir}, 32'd52);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ir", {16'h0, ir}, 32'd52);
      chk("bp_pc", {16'h0, ir_pc}, 32'h10);
      chk("bp_addr", {16'h0, mem_addr}, 32'h11);
      chk("bp_vld", {31'h0, ir_valid}, 32'd1);
      chk("bp_cnt", {16'h0, fetch_count}, 32'd1);
    end
    ir_ready = 1'b1;
    step();
    chk("bp_ir1", {16'h0, ir}, 32'd18);
    chk("bp_pc1", {16'h0, ir_pc}, 32'h11);
    step();
    chk("bp_ir2", {16'h0, ir}, 32'd96);
    chk("bp_pc2", {16'h0, ir_pc}, 32'h12);

    // jump
    jump_en = 1'b1; jump_addr = 16'h0005;
    step();
    jump_en = 1'b0;
    chk("jmp_bub", {31'h0, ir_valid}, 32'd0);
    chk("jmp_addr", {16'h0, mem_addr}, 32'h5);
    step();
    chk("jmp_ir", {16'h0, ir}, 32'd144);
    chk("jmp_pc", {16'h0, ir_pc}, 32'h5);
    chk("jmp_vld", {31'h0, ir_valid}, 32'd1);
    step();
    chk("jmp_ir6", {16'h0, ir}, {16'h0, dflt(16'h6)});
    chk("jmp_pc6", {16'h0, ir_pc}, 32'h6);

    // wrap, then halt with jump
    halt = 1'b1;
    step();
    halt = 1'b0;
    start = 1'b1; start_addr = 16'hFFFE;
    step();
    start = 1'b0;
    step();
    chk("wr_pc0", {16'h0, ir_pc}, 32'hFFFE);
    step();
    chk("wr_pc1", {16'h0, ir_pc}, 32'hFFFF);
    chk("wr_ir1", {16'h0, ir}, {16'h0, dflt(16'hFFFF)});
    step();
    chk("wr_pc2", {16'h0, ir_pc}, 32'h0);
    chk("wr_addr", {16'h0, mem_addr}, 32'h1);
    halt = 1'b1; jump_en = 1'b1; jump_addr = 16'h1234;
    step();
    halt = 1'b0; jump_en = 1'b0;
    chk("hj_rd", {31'h0, mem_rd}, 32'd0);
    chk("hj_busy", {31'h0, busy}, 32'd0);
    chk("hj_vld", {31'h0, ir_valid}, 32'd0);
    chk("hj_addr", {16'h0, mem_addr}, 32'h1);
    chk("hj_pc", {16'h0, ir_pc}, 32'h0);
    chk("hj_cnt", {16'h0, fetch_count}, 32'd3);

    // reset while stalled, then restart
    start = 1'b1; start_addr = 16'h0010;
    step();
    start = 1'b0; ir_ready = 1'b0;
    step();
    step();
    chk("rs_vld", {31'h0, ir_valid}, 32'd1);
    chk("rs_ir", {16'h0, ir}, 32'd52);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_vld0", {31'h0, ir_valid}, 32'd0);
    chk("rs_addr", {16'h0, mem_addr}, 32'h0);
    chk("rs_rd", {31'h0, mem_rd}, 32'd0);
    chk("rs_cnt", {16'h0, fetch_count}, 32'h0);
    step();
    rst_n = 1'b1;
    ir_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("rs_t0", {16'h0, mem_addr}, 32'h10);
    stream5("re");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction fetch stage that sits directly upstream of the per-core instruction RAM. It owns the program counter, drives the RAM's 16-bit address bus and read strobe, captures the returned 16-bit word into an instruction register, and presents it to the decode stage through a valid/ready handshake. It supports start, jump redirection, halt and decode back-pressure, at one instruction per cycle.

## Interface
- ADDR_W, 16, address width of the instruction RAM
- DATA_W, 16, instruction word width
- RESET_PC, 16'h0000, value of mem_addr after reset
- clk  input  1  system clock; all state changes on posedge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; begins fetching at start_addr (honoured only in IDLE)
- start_addr  input  ADDR_W  first fetch address, sampled with start
- jump_en  input  1  redirect request (honoured only in FETCH)
- jump_addr  input  ADDR_W  redirect target, sampled with jump_en
- halt  input  1  stop fetching and flush; return to IDLE
- mem_addr  output  ADDR_W  address to instruction RAM (registered)
- mem_rd  output  1  read strobe to instruction RAM (registered)
- mem_data  input  DATA_W  instruction RAM data output
- ir  output  DATA_W  instruction register
- ir_pc  output  ADDR_W  address from which ir was fetched
- ir_valid  output  1  ir holds an unconsumed instruction
- ir_ready  input  1  decode accepts ir this cycle
- busy  output  1  high in FETCH state
- fetch_count  output  16  instructions captured since last start, saturating

## Operation
- Two states: IDLE, FETCH. mem_rd = 1 exactly when state is FETCH; busy mirrors it.
- Event priority at each posedge: halt > jump_en > start > capture.
- IDLE: on start -> FETCH, mem_addr <= start_addr, fetch_count <= 0, ir_valid <= 0. Other inputs except halt ignored.
- FETCH, capture condition (no halt, no jump_en) and (!ir_valid || ir_ready): ir <= mem_data, ir_pc <= mem_addr, ir_valid <= 1, mem_addr <= mem_addr + 1, fetch_count <= fetch_count + 1 (holds at 16'hFFFF).
- FETCH, ir_valid && !ir_ready (stall): ir, ir_pc, ir_valid, mem_addr, fetch_count all hold; mem_rd stays 1 (RAM re-reads same address, harmless).
- FETCH, ir_valid && ir_ready with no new capture possible (only under jump/halt): ir_valid <= 0.
- jump_en in FETCH: mem_addr <= jump_addr, ir_valid <= 0 (word on mem_data belongs to old address and is discarded; any pending ir is flushed even if ir_ready is low). No capture that cycle. start in FETCH ignored.
- halt (any state): state <= IDLE, mem_rd <= 0, ir_valid <= 0; mem_addr, ir, ir_pc, fetch_count hold.
- Address arithmetic modulo 2^ADDR_W: 16'hFFFF + 1 = 16'h0000, fetching continues.
- mem_data is sampled only in FETCH (RAM drives Z when mem_rd = 0).

## Timing
- Reset (async, rst_n low): state IDLE, mem_addr = RESET_PC, mem_rd = 0, ir = 0, ir_pc = 0, ir_valid = 0, busy = 0, fetch_count = 0. Reset asserted mid-fetch aborts immediately; pending ir is lost.
- RAM returns data during the low phase of the cycle in which mem_addr/mem_rd are presented; the word is stable at the next posedge.
- Latency: start sampled at posedge T0 -> mem_addr/mem_rd valid after T0 -> ir/ir_valid valid after T1.
- Jump sampled at Tj -> target word in ir after Tj+1; one bubble cycle (ir_valid = 0 after Tj).
- Throughput: one instruction per cycle while ir_ready stays high.
- ir_valid, once high, deasserts only on consumption without new capture, jump, halt or reset; ir stable while stalled.

## Test plan
- Reset then idle: rst_n low mid-cycle -> all outputs at reset values immediately; no start -> mem_rd stays 0 for 10 cycles.
- Streaming: RAM mem[0x10..0x14] = 52,18,96,112,183; start, start_addr = 0x0010, ir_ready = 1 -> ir = 52,18,96,112,183 on consecutive cycles after T1, ir_pc = 0x10..0x14, fetch_count = 5.
- Back-pressure: same image, ir_ready low for 3 cycles after first capture -> ir = 52, ir_pc = 0x10, mem_addr = 0x11 held 3 cycles; ir_ready high -> 18 next cycle, no word skipped or duplicated.
- Jump: while streaming at ir_pc = 0x12, jump_en with jump_addr = 0x0005, mem[5] = 144 -> ir_valid = 0 for one cycle, then ir = 144, ir_pc = 0x0005, then 0x0006 follows.
- Wrap and halt: start_addr = 0xFFFE -> ir_pc 0xFFFE, 0xFFFF, 0x0000; halt asserted together with jump_en -> IDLE, mem_rd = 0, ir_valid = 0, mem_addr unchanged.
- Reset mid-operation then restart: rst_n pulsed while stalled with ir_valid = 1 -> ir_valid = 0, mem_addr = RESET_PC; subsequent start at 0x0010 reproduces the streaming sequence with fetch_count restarting at 0.
